// File: rtl/aer_event_packetizer_pkg.sv
// ---------------------------------------------------------------------------
// aer_event_packetizer_pkg
// Shared types and constants for the AER event packetizer.
//   AER_PKT_W   packet width for the default address widths
//   aer_pkt_t   packed packet layout {ts (optional), pol, x, y}
//   DROP_CNT_W  width of the saturating dropped-event counter
//   sat_inc()   saturating increment for the drop counter
// Configuration macro: AER_TIMESTAMP_EN adds the ts field to the packet.
// ---------------------------------------------------------------------------
package aer_event_packetizer_pkg;

  localparam int AER_X_W    = 4;
  localparam int AER_Y_W    = 4;
  localparam int AER_TS_W   = 16;
  localparam int DROP_CNT_W = 8;

`ifdef AER_TIMESTAMP_EN
  localparam int AER_PKT_W = AER_TS_W + 1 + AER_X_W + AER_Y_W;

  typedef struct packed {
    logic [AER_TS_W-1:0] ts;
    logic                pol;
    logic [AER_X_W-1:0]  x;
    logic [AER_Y_W-1:0]  y;
  } aer_pkt_t;
`else
  localparam int AER_PKT_W = 1 + AER_X_W + AER_Y_W;

  typedef struct packed {
    logic               pol;
    logic [AER_X_W-1:0] x;
    logic [AER_Y_W-1:0] y;
  } aer_pkt_t;
`endif

  // Counter sticks at all-ones instead of wrapping back to zero.
  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (v == {DROP_CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/aer_evt_fifo.sv
// ---------------------------------------------------------------------------
// aer_evt_fifo
// Synchronous first-word-fall-through FIFO for AER packets.
//   clk_i, reset_i  clock, asynchronous active-high reset
//   clear_i         synchronous flush (priority over push/pop)
//   push_i, wdata_i write request and data
//   pop_i           read request (head advances)
//   rdata_o         head entry, forced to 0 while empty
//   count_o         occupancy 0..DEPTH
//   full_o, empty_o derived from the occupancy counter
// DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module aer_evt_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 9,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CW-1:0]    count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count == '0);
  assign full_o  = (count == CW'(DEPTH));
  assign do_pop  = pop_i & ~empty_o & ~clear_i;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign do_push = push_i & (~full_o | do_pop) & ~clear_i;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // NOTE: the storage array has no reset; validity comes from the counter,
  // which keeps it a plain RAM.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= wdata_i;
  end

  assign rdata_o = empty_o ? '0 : mem[rd_ptr];
  assign count_o = count;

endmodule

// File: rtl/aer_event_packetizer.sv
// ---------------------------------------------------------------------------
// aer_event_packetizer
// Captures granted pixel events from the level-0 arbiter, formats them into
// AER packets, buffers them and streams them out on valid/ready.
//   clk_i, reset_i  clock, asynchronous active-high reset
//   clear_i         synchronous flush of FIFO, counters and flags
//   evt_valid_i     one-cycle grant strobe with x_add_i, y_add_i, pol_i
//   arb_enable_o    registered throttle to the arbiter (low when nearly full)
//   pkt_o           FIFO head packet {[ts,] pol, x, y}, 0 when empty
//   pkt_valid_o     pkt_o valid; pkt_ready_i accepts it
//   fifo_cnt_o      FIFO occupancy
//   overflow_o      sticky drop flag; drop_cnt_o saturating drop count
// Configuration macro: AER_TIMESTAMP_EN prefixes each packet with a
// free-running TS_W-bit timestamp taken in the push cycle.
// ---------------------------------------------------------------------------
module aer_event_packetizer
  import aer_event_packetizer_pkg::*;
#(
  parameter int X_W        = AER_X_W,
  parameter int Y_W        = AER_Y_W,
  parameter int FIFO_DEPTH = 8,
  parameter int TS_W       = AER_TS_W,
  parameter int AF_MARGIN  = 2,
`ifdef AER_TIMESTAMP_EN
  localparam int PKT_W     = TS_W + 1 + X_W + Y_W,
`else
  localparam int PKT_W     = 1 + X_W + Y_W,
`endif
  localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  clear_i,
  input  logic                  evt_valid_i,
  input  logic [X_W-1:0]        x_add_i,
  input  logic [Y_W-1:0]        y_add_i,
  input  logic                  pol_i,
  output logic                  arb_enable_o,
  output logic [PKT_W-1:0]      pkt_o,
  output logic                  pkt_valid_o,
  input  logic                  pkt_ready_i,
  output logic [CNT_W-1:0]      fifo_cnt_o,
  output logic                  overflow_o,
  output logic [DROP_CNT_W-1:0] drop_cnt_o
);

  // Reject configurations the throttle and pointer logic cannot support.
  if (AF_MARGIN < 1 || AF_MARGIN >= FIFO_DEPTH || FIFO_DEPTH < 4 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TS_W < 1) begin : g_bad_cfg
    $error("aer_event_packetizer: invalid FIFO_DEPTH/AF_MARGIN/TS_W");
  end

  logic [PKT_W-1:0] pkt_in;
  logic [PKT_W-1:0] fifo_rdata;
  logic [CNT_W-1:0] fifo_cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] free_next;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic             drop;

`ifdef AER_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)      ts_q <= '0;
    else if (clear_i) ts_q <= '0;
    else              ts_q <= ts_q + 1'b1;
  end

  assign pkt_in = {ts_q, pol_i, x_add_i, y_add_i};
`else
  assign pkt_in = {pol_i, x_add_i, y_add_i};
`endif

  // Clear wins over everything: the event in the clear cycle is neither
  // stored nor counted as a drop.
  assign pop  = ~fifo_empty & pkt_ready_i & ~clear_i;
  assign push = evt_valid_i & (~fifo_full | pop) & ~clear_i;
  assign drop = evt_valid_i & fifo_full & ~pop & ~clear_i;

  // Occupancy after this edge; the throttle looks ahead so the arbiter,
  // which reacts one cycle late, still has AF_MARGIN slots for its grant.
  assign cnt_next  = fifo_cnt + CNT_W'(push) - CNT_W'(pop);
  assign free_next = CNT_W'(FIFO_DEPTH) - cnt_next;

  aer_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PKT_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (clear_i),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (pkt_in),
    .rdata_o (fifo_rdata),
    .count_o (fifo_cnt),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      arb_enable_o <= 1'b1;
      overflow_o   <= 1'b0;
      drop_cnt_o   <= '0;
    end else if (clear_i) begin
      arb_enable_o <= 1'b1;
      overflow_o   <= 1'b0;
      drop_cnt_o   <= '0;
    end else begin
      arb_enable_o <= (free_next > CNT_W'(AF_MARGIN));
      if (drop) begin
        overflow_o <= 1'b1;
        drop_cnt_o <= sat_inc(drop_cnt_o);
      end
    end
  end

  assign pkt_o       = fifo_rdata;
  assign pkt_valid_o = ~fifo_empty;
  assign fifo_cnt_o  = fifo_cnt;

endmodule

// File: tb/tb_aer_event_packetizer.sv
// ---------------------------------------------------------------------------
// tb_aer_event_packetizer
// Directed stimulus for aer_event_packetizer. Accepted events are queued as
// expected packets; a monitor pops and compares whenever a packet is
// handed over (pkt_valid_o & pkt_ready_i). Status outputs are checked
// directly against hand-computed values.
// ---------------------------------------------------------------------------
module tb_aer_event_packetizer;

  localparam int X_W   = 4;
  localparam int Y_W   = 4;
  localparam int DEPTH = 8;
  localparam int TS_W  = 4;
  localparam int AF    = 2;
  localparam int CNT_W = 4;
`ifdef AER_TIMESTAMP_EN
  localparam int PKT_W = TS_W + 1 + X_W + Y_W;
`else
  localparam int PKT_W = 1 + X_W + Y_W;
`endif

  logic             clk_i = 1'b0;
  logic             reset_i;
  logic             clear_i;
  logic             evt_valid_i;
  logic [X_W-1:0]   x_add_i;
  logic [Y_W-1:0]   y_add_i;
  logic             pol_i;
  logic             arb_enable_o;
  logic [PKT_W-1:0] pkt_o;
  logic             pkt_valid_o;
  logic             pkt_ready_i;
  logic [CNT_W-1:0] fifo_cnt_o;
  logic             overflow_o;
  logic [7:0]       drop_cnt_o;

  logic [PKT_W-1:0] sb [$];
  int total = 0;
  int bad   = 0;

  aer_event_packetizer #(
    .X_W        (X_W),
    .Y_W        (Y_W),
    .FIFO_DEPTH (DEPTH),
    .TS_W       (TS_W),
    .AF_MARGIN  (AF)
  ) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .clear_i      (clear_i),
    .evt_valid_i  (evt_valid_i),
    .x_add_i      (x_add_i),
    .y_add_i      (y_add_i),
    .pol_i        (pol_i),
    .arb_enable_o (arb_enable_o),
    .pkt_o        (pkt_o),
    .pkt_valid_o  (pkt_valid_o),
    .pkt_ready_i  (pkt_ready_i),
    .fifo_cnt_o   (fifo_cnt_o),
    .overflow_o   (overflow_o),
    .drop_cnt_o   (drop_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [PKT_W-1:0] mk(input logic [TS_W-1:0] ts, input logic pol,
                                          input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
`ifdef AER_TIMESTAMP_EN
    return {ts, pol, x, y};
`else
    return {pol, x, y};
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus; an accepted event's packet goes to the queue.
  task automatic step(input logic ev, input logic pol, input logic [X_W-1:0] x,
                      input logic [Y_W-1:0] y, input logic accept, input logic [TS_W-1:0] ts);
    evt_valid_i = ev;
    pol_i       = pol;
    x_add_i     = x;
    y_add_i     = y;
    if (ev && accept) sb.push_back(mk(ts, pol, x, y));
    @(posedge clk_i);
    #1;
    evt_valid_i = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, 1'b0, '0);
  endtask

  // Compares the head packet at the falling edge before it is popped.
  task automatic monitor();
    logic [PKT_W-1:0] e;
    forever begin
      @(negedge clk_i);
      if (!reset_i && pkt_valid_o && pkt_ready_i) begin
        if (sb.size() == 0) begin
          check("unexpected_pkt", 32'(sb.size()), 32'd1);
        end else begin
          e = sb.pop_front();
          check("pkt_order", 32'(pkt_o), 32'(e));
        end
      end
    end
  endtask

  initial begin
    reset_i     = 1'b1;
    clear_i     = 1'b0;
    evt_valid_i = 1'b0;
    x_add_i     = '0;
    y_add_i     = '0;
    pol_i       = 1'b0;
    pkt_ready_i = 1'b0;
    fork
      monitor();
    join_none

    // 1: reset values
    repeat (3) @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    check("rst_valid",    32'(pkt_valid_o),  32'd0);
    check("rst_pkt",      32'(pkt_o),        32'd0);
    check("rst_cnt",      32'(fifo_cnt_o),   32'd0);
    check("rst_arb_en",   32'(arb_enable_o), 32'd1);
    check("rst_overflow", 32'(overflow_o),   32'd0);
    check("rst_drop",     32'(drop_cnt_o),   32'd0);

    // 2: single event, visible next cycle, drained one cycle after ready
    step(1'b1, 1'b1, 4'd3, 4'd5, 1'b1, '0);
    check("single_valid", 32'(pkt_valid_o), 32'd1);
    check("single_pkt",   32'(pkt_o),       32'(mk('0, 1'b1, 4'd3, 4'd5)));
    check("single_cnt",   32'(fifo_cnt_o),  32'd1);
    pkt_ready_i = 1'b1;
    idle(1);
    pkt_ready_i = 1'b0;
    check("single_empty", 32'(pkt_valid_o), 32'd0);
    check("single_cnt0",  32'(fifo_cnt_o),  32'd0);

    // 3: backpressure fill, throttle at 6, drop on the 9th event
    for (int i = 0; i < 8; i++) begin
      step(1'b1, i[0], 4'(i), 4'(15 - i), 1'b1, '0);
      check("bp_cnt",    32'(fifo_cnt_o),   32'(i + 1));
      check("bp_arb_en", 32'(arb_enable_o), 32'((i + 1) <= 5));
    end
    step(1'b1, 1'b1, 4'd9, 4'd9, 1'b0, '0);
    check("bp_overflow", 32'(overflow_o), 32'd1);
    check("bp_drop",     32'(drop_cnt_o), 32'd1);
    check("bp_cnt_full", 32'(fifo_cnt_o), 32'd8);
    pkt_ready_i = 1'b1;
    idle(8);
    pkt_ready_i = 1'b0;
    check("bp_drained",  32'(fifo_cnt_o),   32'd0);
    check("bp_arb_back", 32'(arb_enable_o), 32'd1);
    check("bp_sticky",   32'(overflow_o),   32'd1);

    // 4: full FIFO with simultaneous push and pop, then drop saturation
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 4'(i), 4'(i), 1'b1, '0);
    pkt_ready_i = 1'b1;
    for (int j = 0; j < 3; j++) begin
      step(1'b1, 1'b1, 4'(10 + j), 4'(j), 1'b1, '0);
      check("pp_cnt",    32'(fifo_cnt_o),   32'd8);
      check("pp_drop",   32'(drop_cnt_o),   32'd1);
      check("pp_arb_en", 32'(arb_enable_o), 32'd0);
    end
    pkt_ready_i = 1'b0;
    for (int i = 0; i < 260; i++) step(1'b1, 1'b0, 4'hE, 4'hE, 1'b0, '0);
    check("sat_drop", 32'(drop_cnt_o), 32'hFF);
    check("sat_cnt",  32'(fifo_cnt_o), 32'd8);
    pkt_ready_i = 1'b1;
    idle(8);
    pkt_ready_i = 1'b0;
    check("pp_drained", 32'(fifo_cnt_o), 32'd0);

    // 5: clear with 5 queued; event in the clear cycle is discarded
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 4'(i + 1), 4'(i), 1'b1, '0);
    check("clr_pre_cnt", 32'(fifo_cnt_o), 32'd5);
    clear_i = 1'b1;
    step(1'b1, 1'b1, 4'd7, 4'd7, 1'b0, '0);
    clear_i = 1'b0;
    sb.delete();
    check("clr_cnt",      32'(fifo_cnt_o),   32'd0);
    check("clr_valid",    32'(pkt_valid_o),  32'd0);
    check("clr_overflow", 32'(overflow_o),   32'd0);
    check("clr_drop",     32'(drop_cnt_o),   32'd0);
    check("clr_arb_en",   32'(arb_enable_o), 32'd1);
    step(1'b1, 1'b0, 4'd2, 4'd9, 1'b1, '0);
    pkt_ready_i = 1'b1;
    idle(1);
    pkt_ready_i = 1'b0;
    check("post_clr_cnt", 32'(fifo_cnt_o), 32'd0);

    // 6: asynchronous reset mid-operation
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 4'(i), 4'd1, 1'b1, '0);
    #2;
    reset_i = 1'b1;
    #1;
    sb.delete();
    check("mid_rst_valid",  32'(pkt_valid_o),  32'd0);
    check("mid_rst_cnt",    32'(fifo_cnt_o),   32'd0);
    check("mid_rst_pkt",    32'(pkt_o),        32'd0);
    check("mid_rst_arb_en", 32'(arb_enable_o), 32'd1);
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;

`ifdef AER_TIMESTAMP_EN
    // 7: timestamps; after the clear edge the counter reads k in cycle k
    clear_i = 1'b1;
    idle(1);
    clear_i = 1'b0;
    pkt_ready_i = 1'b1;
    for (int k = 0; k < 19; k++) begin
      case (k)
        0:       step(1'b1, 1'b1, 4'd1, 4'd1, 1'b1, 4'd0);
        3:       step(1'b1, 1'b0, 4'd2, 4'd2, 1'b1, 4'd3);
        15:      step(1'b1, 1'b1, 4'd3, 4'd3, 1'b1, 4'd15);
        17:      step(1'b1, 1'b0, 4'd4, 4'd4, 1'b1, 4'd1);
        default: idle(1);
      endcase
    end
    pkt_ready_i = 1'b0;
    check("ts_drained", 32'(fifo_cnt_o), 32'd0);
`endif

    idle(2);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
